// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 access codes and byte-enable constants for the LSU
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-enable / store-lane replication and load lane extract with sign/zero extension
// ports: funct3_i access code, addr_i byte offset, wdata_i store data, rdata_i raw bus word;
//        be_o byte enables, wdata_o replicated store data, rdata_o extended load value
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b       = rdata_i[{addr_i, 3'b000} +: 8];
        h       = rdata_i[{addr_i[1], 4'b0000} +: 16];
        be_o    = funct3_i[1:0] == 2'b00 ? 4'b0001 << addr_i :
                  funct3_i[1:0] == 2'b01 ? 4'b0011 << {addr_i[1], 1'b0} : BE_WORD;
        wdata_o = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
                  funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
                  funct3_i == F3_BU ? {24'b0, b} :
                  funct3_i == F3_H  ? {{16{h[15]}}, h} :
                  funct3_i == F3_HU ? {16'b0, h} : rdata_i;
    end
endmodule

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: stalls the core while a load/store runs over a handshaked variable-latency bus
// ports: core side mem_read/mem_write/funct3/addr/wdata in, rdata/stall/fault/misalign out;
//        bus side bus_req/bus_we/bus_addr/bus_be/bus_wdata out, bus_gnt/bus_rvalid/bus_rdata/bus_err in
module lsu_bus_bridge
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);
    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic        we_q;
    logic [31:0] rdata_q, bus_addr_q, bus_wdata_q;
    logic [3:0]  bus_be_q;
    logic        fault_q, misalign_q, bus_req_q, bus_we_q;
    logic        req, bad, mis, timeout;
    logic [3:0]  be;
    logic [31:0] wd, ext;
    always_comb begin
        req     = mem_read | mem_write;
        bad     = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) | (mem_read & mem_write);
        mis     = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) || (funct3 == F3_W && addr[1:0] != 2'b00);
        timeout = cnt_q == 8'(TIMEOUT_CYCLES - 1);
    end
    // live request drives lane logic in IDLE, the captured one drives load extraction later
    lsu_lane_align u_align (
        .funct3_i (state_q == IDLE ? funct3 : f3_q),
        .addr_i   (state_q == IDLE ? addr[1:0] : lo_q),
        .wdata_i  (wdata),
        .rdata_i  (bus_rdata),
        .be_o     (be),
        .wdata_o  (wd),
        .rdata_o  (ext)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            lo_q        <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            misalign_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    f3_q    <= funct3;
                    lo_q    <= addr[1:0];
                    we_q    <= mem_write;
                    cnt_q   <= '0;
                    rdata_q <= '0;
                    if (bad || mis) begin
                        state_q    <= DONE;
                        fault_q    <= bad;
                        misalign_q <= mis;
                    end else begin
                        state_q     <= REQ;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_write;
                        bus_addr_q  <= {addr[31:2], 2'b00};
                        bus_be_q    <= be;
                        bus_wdata_q <= wd;
                    end
                end
                // timeout wins over a grant or response arriving in the final budgeted cycle
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (timeout) begin
                        state_q   <= DONE;
                        fault_q   <= 1'b1;
                        bus_req_q <= 1'b0;
                    end else if (bus_gnt) begin
                        state_q   <= WAIT_RESP;
                        bus_req_q <= 1'b0;
                    end
                end
                WAIT_RESP: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (timeout) begin
                        state_q <= DONE;
                        fault_q <= 1'b1;
                    end else if (bus_rvalid) begin
                        state_q <= DONE;
                        fault_q <= bus_err;
                        rdata_q <= (bus_err || we_q) ? 32'h0 : ext;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    fault_q    <= 1'b0;
                    misalign_q <= 1'b0;
                end
            endcase
        end
    end
    assign stall     = (mem_read | mem_write) & (state_q != DONE) & ~reset;
    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign misalign  = misalign_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge: randomized and directed checking of lsu_bus_bridge against a transaction-level model
module tb_lsu_bus_bridge;
    localparam int TO = 8;
    logic        clk = 1'b0;
    logic        reset, mem_read, mem_write, bus_gnt, bus_rvalid, bus_err;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, bus_rdata, rdata, bus_addr, bus_wdata;
    logic        stall, fault, misalign, bus_req, bus_we;
    logic [3:0]  bus_be;
    int checks = 0;
    int failures = 0;

    lsu_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault), .misalign(misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got=hung exp=finish");
        $fatal(1, "simulation did not terminate");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'((raw >> (8 * int'(a[1:0]))) & 32'hFF);
        h = 16'((raw >> (16 * int'(a[1]))) & 32'hFFFF);
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return raw;
        endcase
    endfunction

    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int gd, input int rdl, input logic [31:0] raw, input logic er);
        logic bad, mis, ill, to, ef, em, done, ereq;
        logic [31:0] erd, ewd;
        logic [3:0]  ebe;
        int n, stalls, estalls;
        bad  = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (rd && wr);
        mis  = ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
        ill  = bad || mis;
        n    = gd + 1 + rdl;
        to   = !ill && (n >= TO);
        ef   = ill ? bad : (to || er);
        em   = ill && mis;
        erd  = (ill || to || er) ? 32'h0 : extract(f3, a, raw);
        estalls = ill ? 1 : 1 + (to ? TO : n);
        case (f3[1:0])
            2'b00:   begin ebe = 4'(1 << a[1:0]);       ewd = {4{wd[7:0]}};  end
            2'b01:   begin ebe = 4'(3 << (2 * a[1]));   ewd = {2{wd[15:0]}}; end
            default: begin ebe = 4'hF;                  ewd = wd;            end
        endcase
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            bus_gnt    = (c == 1 + gd) || (c > 1 + gd && $urandom % 4 == 0);
            bus_rvalid = (c == 1 + gd + rdl) || (c >= 1 && c <= 1 + gd && $urandom % 3 == 0);
            bus_rdata  = (c == 1 + gd + rdl) ? raw : $urandom;
            bus_err    = (c == 1 + gd + rdl) ? er : 1'($urandom);
            #1;
            if (!stall) done = 1'b1;
            else stalls++;
            ereq = !ill && c >= 1 && c <= 1 + gd && c <= TO;
            check("bus_req", {31'b0, bus_req}, {31'b0, ereq});
            if (ereq) begin
                check("bus_addr", bus_addr, {a[31:2], 2'b00});
                check("bus_be", {28'b0, bus_be}, {28'b0, ebe});
                check("bus_wdata", bus_wdata, ewd);
                check("bus_we", {31'b0, bus_we}, {31'b0, wr});
            end
        end
        check("done_reached", {31'b0, done}, 32'd1);
        check("stall_cycles", stalls, estalls);
        check("fault", {31'b0, fault}, {31'b0, ef});
        check("misalign", {31'b0, misalign}, {31'b0, em});
        if (!wr || ill) check("rdata", rdata, erd);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_err = 1'b1;
        #1;
        check("idle_stall", {31'b0, stall}, 32'd0);
        check("idle_fault", {31'b0, fault}, 32'd0);
        check("idle_misalign", {31'b0, misalign}, 32'd0);
        check("idle_bus_req", {31'b0, bus_req}, 32'd0);
        if (!wr || ill) check("rdata_hold", rdata, erd);
        @(negedge clk);
        bus_rvalid = 1'b0; bus_err = 1'b0;
        #1;
        check("late_rvalid_fault", {31'b0, fault}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0; wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_bus", {bus_req, bus_we, bus_be, 26'b0}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_flags", {30'b0, fault, misalign}, 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_read = 1'b0;

        txn(1, 0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0);
        txn(1, 0, 3'b000, 32'h13, 32'h0, 0, 1, 32'h80FF1234, 0);
        txn(1, 0, 3'b100, 32'h13, 32'h0, 1, 2, 32'h80FF1234, 0);
        txn(1, 0, 3'b001, 32'h12, 32'h0, 0, 1, 32'h80FF1234, 0);
        txn(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 0, 1, 32'h0, 0);
        txn(1, 0, 3'b010, 32'h06, 32'h0, 0, 1, 32'h0, 0);
        txn(1, 0, 3'b010, 32'h40, 32'h0, 3, 30, 32'h0, 0);
        txn(1, 0, 3'b010, 32'h44, 32'h0, 1, 2, 32'h12345678, 1);
        txn(1, 1, 3'b010, 32'h48, 32'h0, 0, 1, 32'h0, 0);
        txn(1, 0, 3'b011, 32'h48, 32'h0, 0, 1, 32'h0, 0);

        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h80;
        @(negedge clk);
        bus_gnt = 1'b1;
        #1;
        check("rst_mid_req", {31'b0, bus_req}, 32'd1);
        @(negedge clk);
        bus_gnt = 1'b0; reset = 1'b1;
        #1;
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_read = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        #1;
        check("rst_mid_bus", {bus_req, bus_we, bus_be, 26'b0}, 32'd0);
        check("rst_mid_addr", bus_addr, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_flags", {30'b0, fault, misalign}, 32'd0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        check("rst_mid_no_done", {rdata[30:0], fault}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic r, w;
            int k;
            k = $urandom % 16;
            r = (k == 0) || (k >= 8);
            w = (k == 0) || (k < 8 && k > 0);
            txn(r, w, 3'($urandom), $urandom, $urandom, $urandom_range(0, 5), $urandom_range(1, 5),
                $urandom, $urandom % 6 == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
